// File: rtl/aes_cipher_if.sv
// Host/key-store handshake bundle for the iterative AES-128 cipher core.
interface aes_cipher_if;
  logic         start;
  logic         key_rdy;
  logic [127:0] din;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  modport master (output start, key_rdy, din, rk, input rk_idx, busy, done, dout);
  modport slave  (input start, key_rdy, din, rk, output rk_idx, busy, done, dout);
endinterface

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption: one round per clock, round key fetched by rk_idx.
// Includes the byte-wide subbyte S-box used for all 16 state bytes.
module subbyte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a).
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_cipher_core (
  input logic         clk,
  input logic         reset,
  aes_cipher_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state;
  logic [3:0]   round_cnt;
  logic [127:0] state_reg;
  logic [127:0] sb_flat;
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i is row i%4, column i/4; ShiftRows pulls row r from column (c+r)%4.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    subbyte u_sbox (.a(state_reg[127-8*i -: 8]), .y(sb_flat[127-8*i -: 8]));
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_flat[127-8*(r+4*c) -: 8] = sb_flat[127-8*(r+4*((c+r)%4)) -: 8];
    end

    assign a0 = sr_flat[127-32*c -: 8];
    assign a1 = sr_flat[119-32*c -: 8];
    assign a2 = sr_flat[111-32*c -: 8];
    assign a3 = sr_flat[103-32*c -: 8];

    assign mc_flat[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_flat[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_flat[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_flat[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // rk_idx is registered one step ahead so the key store sees the index
  // of the round being computed, never a path from start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      round_cnt  <= 4'd0;
      state_reg  <= 128'd0;
      bus.dout   <= 128'd0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.rk_idx <= 4'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.key_rdy) begin
            state_reg  <= bus.din ^ bus.rk;
            round_cnt  <= 4'd1;
            bus.rk_idx <= 4'd1;
            bus.busy   <= 1'b1;
            state      <= ROUND;
          end
        end
        ROUND: begin
          state_reg  <= mc_flat ^ bus.rk;
          round_cnt  <= round_cnt + 4'd1;
          bus.rk_idx <= round_cnt + 4'd1;
          if (round_cnt == 4'd9) state <= FINAL;
        end
        FINAL: begin
          bus.dout   <= sr_flat ^ bus.rk;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          bus.rk_idx <= 4'd0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: FIPS-197 vectors, handshake corner cases and random
// blocks against a GF(2^8)-arithmetic AES model with its own key store.
module tb_aes_cipher_core;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset;
  int   testCount = 0;
  int   failCount = 0;
  int   cycle = 0;

  logic [7:0]   sboxRef [256];
  logic [127:0] roundKeys [11];

  aes_cipher_if bus ();
  aes_cipher_core dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // The key store answers combinationally for whichever index the core asks for.
  assign bus.rk = (bus.rk_idx <= 4'd10) ? roundKeys[bus.rk_idx] : 128'd0;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map.
  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'd0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic loadKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxRef[t[31:24]], sboxRef[t[23:16]], sboxRef[t[15:8]], sboxRef[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) roundKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] refEncrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ roundKeys[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sboxRef[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(8'h02, t[r]) ^ gmul(8'h03, t[(r+1)%4]) ^ t[(r+2)%4] ^ t[(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ roundKeys[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Pulses start for one edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [127:0] pt);
    @(negedge clk);
    bus.din   = pt;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = rand128();
  endtask

  // Watches the run cycle by cycle; extraAt>=0 injects a second start there
  // and keeps watching past done so stray pulses are counted.
  task automatic waitDone(input int extraAt, output logic [127:0] ct, output int lat,
                          output logic [39:0] seq, output int busyCnt, output int doneCnt);
    ct = 128'd0; lat = -1; seq = 40'd0; busyCnt = 0; doneCnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == extraAt) begin
        bus.start = 1'b1;
        bus.din   = rand128();
      end else if (extraAt >= 0 && c == extraAt + 1) begin
        bus.start = 1'b0;
      end
      if (c < 10) seq = {seq[35:0], bus.rk_idx};
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        doneCnt++;
        if (lat < 0) begin
          lat = c;
          ct  = bus.dout;
        end
      end
      if (lat >= 0 && extraAt < 0) break;
    end
  endtask

  task automatic watchIdle(input int cycles, output int busyCnt, output int doneCnt);
    busyCnt = 0; doneCnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.busy) busyCnt++;
      if (bus.done) doneCnt++;
    end
  endtask

  initial begin
    logic [127:0] ct, ct2, pt, key, expCt;
    logic [39:0]  seq;
    int           lat, busyCnt, doneCnt, doneAt1, doneAt2;

    bus.start = 1'b0; bus.key_rdy = 1'b0; bus.din = 128'd0; reset = 1'b0;
    buildSbox();
    loadKey(KEY_B);
    repeat (3) @(negedge clk);
    checkOutput("resetDout", bus.dout, 128'd0);
    checkOutput("resetBusy", 128'(bus.busy), 128'd0);
    checkOutput("resetDone", 128'(bus.done), 128'd0);
    checkOutput("resetRkIdx", 128'(bus.rk_idx), 128'd0);
    reset = 1'b1;
    bus.key_rdy = 1'b1;

    applyStimulus(PT_B);
    waitDone(-1, ct, lat, seq, busyCnt, doneCnt);
    checkOutput("appB.ct", ct, CT_B);
    checkOutput("appB.latency", 128'(lat), 128'd10);
    checkOutput("appB.rkIdxSeq", 128'(seq), 128'h123456789a);
    checkOutput("appB.busyCycles", 128'(busyCnt), 128'd10);
    @(negedge clk);
    checkOutput("appB.donePulse", 128'(bus.done), 128'd0);
    checkOutput("appB.doutHeld", bus.dout, CT_B);

    loadKey(KEY_C);
    applyStimulus(PT_C);
    waitDone(-1, ct, lat, seq, busyCnt, doneCnt);
    checkOutput("appC1.ct", ct, CT_C);
    checkOutput("appC1.latency", 128'(lat), 128'd10);

    loadKey(KEY_B);
    bus.key_rdy = 1'b0;
    applyStimulus(PT_B);
    watchIdle(15, busyCnt, doneCnt);
    checkOutput("gate.busy", 128'(busyCnt), 128'd0);
    checkOutput("gate.done", 128'(doneCnt), 128'd0);
    checkOutput("gate.doutKept", bus.dout, CT_C);
    bus.key_rdy = 1'b1;

    applyStimulus(PT_B);
    waitDone(4, ct, lat, seq, busyCnt, doneCnt);
    checkOutput("ignoredStart.ct", ct, CT_B);
    checkOutput("ignoredStart.doneCount", 128'(doneCnt), 128'd1);
    checkOutput("ignoredStart.latency", 128'(lat), 128'd10);
    bus.start = 1'b0;
    @(negedge clk);

    applyStimulus(PT_B);
    waitDone(-1, ct, lat, seq, busyCnt, doneCnt);
    doneAt1 = cycle;
    checkOutput("b2b.first.ct", ct, CT_B);
    loadKey(KEY_C);
    bus.din   = PT_C;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = rand128();
    checkOutput("b2b.doutHeld", bus.dout, CT_B);
    waitDone(-1, ct2, lat, seq, busyCnt, doneCnt);
    doneAt2 = cycle;
    checkOutput("b2b.second.ct", ct2, CT_C);
    checkOutput("b2b.doneSpacing", 128'(doneAt2 - doneAt1), 128'd11);

    loadKey(KEY_B);
    applyStimulus(PT_B);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort.dout", bus.dout, 128'd0);
    checkOutput("abort.busy", 128'(bus.busy), 128'd0);
    checkOutput("abort.done", 128'(bus.done), 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    watchIdle(15, busyCnt, doneCnt);
    checkOutput("abort.noDone", 128'(doneCnt), 128'd0);
    checkOutput("abort.doutAfter", bus.dout, 128'd0);
    applyStimulus(PT_B);
    waitDone(-1, ct, lat, seq, busyCnt, doneCnt);
    checkOutput("abort.rerun.ct", ct, CT_B);

    for (int n = 0; n < 8; n++) begin
      key = rand128();
      pt  = rand128();
      loadKey(key);
      expCt = refEncrypt(pt);
      applyStimulus(pt);
      waitDone(-1, ct, lat, seq, busyCnt, doneCnt);
      checkOutput($sformatf("random%0d.ct", n), ct, expCt);
      checkOutput($sformatf("random%0d.latency", n), 128'(lat), 128'd10);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative AES-128 encryption datapath: one round per clock, ten rounds plus the initial AddRoundKey. It sits directly downstream of the round-key expansion/storage stage and consumes round key `rk` selected by its own `rk_idx` output. Plaintext in, ciphertext out, with a start/done handshake toward the host-side controller. The S-box lookups reuse the existing `subbyte` module: 16 instances, one per state byte.

## Interface
- No parameters. Key size is fixed at 128 bits and the round count is fixed at 10.
- `clk` input 1: single clock. All state updates occur on the rising edge.
- `reset` input 1: asynchronous, active-low. Low forces the reset values immediately.
- `start` input 1: request to encrypt `din`. Sampled on the rising edge.
- `key_rdy` input 1: high when every round key 0..10 is valid at the key store.
- `din` input 128: plaintext. Bits [127:120] are state byte 0 (row 0, col 0). Bytes are column-major per FIPS-197.
- `rk` input 128: round key addressed by `rk_idx`. It is combinational from the key store, valid in the same cycle, and uses the same byte order as `din`.
- `rk_idx` output 4: round-key index requested this cycle, range 0..10.
- `busy` output 1: high from the cycle after `start` is accepted until `done` is asserted.
- `done` output 1: one-cycle pulse when `dout` becomes valid.
- `dout` output 128: ciphertext. Held stable until the next accepted `start`.

## Operation
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - `rk_idx`=0.
  - `start`=1 and `key_rdy`=1 → state_reg ← `din` ^ `rk`, round_cnt ← 1, go to ROUND.
  - `start` with `key_rdy`=0 is dropped and not queued.
- ROUND (round_cnt 1..9):
  - `rk_idx`=round_cnt.
  - state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ `rk`.
  - round_cnt increments. After round 9 go to FINAL.
- FINAL:
  - `rk_idx`=10.
  - `dout` ← ShiftRows(SubBytes(state_reg)) ^ `rk`. No MixColumns.
  - `done` ← 1 for one cycle, then go to IDLE.
- ShiftRows: row r rotates left by r bytes.
- MixColumns: fixed matrix [02 03 01 01] circulant over GF(2^8).
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
  - All arithmetic is 8-bit XOR/xtime. There are no carries.
- `start` while `busy`=1 is ignored. The current operation is unaffected.
- `din` is sampled only on the accepting edge and may change afterwards.
- `rk` must remain valid for the whole operation. The key store must not be re-expanded while `busy`=1. If it is, the result is undefined and no error is flagged.
- round_cnt is 4 bits and never wraps. FINAL always returns to IDLE.

## Timing
- Reset values while `reset`=0: state IDLE, round_cnt 0, state_reg 0, `dout` 0, `done` 0, `busy` 0, `rk_idx` 0.
- Reset mid-operation aborts immediately. After release the block is in IDLE, `dout`=0, and no `done` is produced.
- Edge E0: `start` is accepted and the initial AddRoundKey is done.
- Edges E1..E9: rounds 1..9.
- Edge E10: the final round is done, and `done`=1 and `dout` become valid in the cycle after E10.
- Latency: 10 cycles from the accepting edge to `done`.
- `busy`=1 in the cycles after E0..E9 (10 cycles). `busy`=0 in the same cycle that `done`=1.
- Back-to-back: `start` high in the `done` cycle is accepted at that edge, IDLE being entered at E10. Throughput is 1 block per 11 cycles.
- `rk_idx` is a registered-state decode with no combinational path from `start`.

## Test plan
- FIPS-197 App. B:
  - Key store loaded from key 2b7e151628aed2a6abf7158809cf4f3c, `key_rdy`=1.
  - `din`=3243f6a8885a308d313198a2e0370734, `start` for 1 cycle.
  - Required: `done` 10 cycles later, `dout`=3925841d02dc09fbdc118597196a0b32, `rk_idx` sequence 0,1,…,10.
- FIPS-197 App. C.1:
  - Key 000102030405060708090a0b0c0d0e0f, `din`=00112233445566778899aabbccddeeff.
  - Required: `dout`=69c4e0d86a7b0430d8cdb78070b4c55a.
- Gating:
  - `start` with `key_rdy`=0 → `busy` stays 0 and no `done`.
  - A second `start` at cycle 4 of an operation → ignored. The App. B result is unchanged and exactly one `done` pulse occurs.
- Back-to-back:
  - App. B then App. C.1, second `start` held high in the first `done` cycle.
  - Required: second `done` exactly 11 cycles after the first, both ciphertexts correct, and the first `dout` held until the second accepting edge.
- Reset abort:
  - Assert `reset`=0 at cycle 5 of an operation.
  - Required: `dout`=0, `busy`=0, `done` never pulses.
  - After release, a new App. B run gives the correct ciphertext.
